// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx and the Peripheral's UART data register.
// The receiver drives data/status (master); the Peripheral returns the read acknowledge (slave).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output parity_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with valid/ack handshake, framing and overrun flags.
// Define UART_RX_PARITY_EN for 8E1 frames (adds the PARITY state and drives parity_err).
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  uart_rx_if.master  bus
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int HALF    = DIVISOR / 2;
  localparam int CNT_W   = ($clog2(DIVISOR) > 13) ? $clog2(DIVISOR) : 13;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic             cnt_full;
  logic             stop_tick;
  logic             accept;

  // Both flops reset high so a reset release never looks like a start edge.
  // NOTE: sequential state always uses non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign cnt_full  = (cnt == DIV_LAST);
  assign stop_tick = (state == STOP) && cnt_full;

`ifdef UART_RX_PARITY_EN
  logic perr;
  assign accept = stop_tick && rx_s && !perr;
`else
  assign accept = stop_tick && rx_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shifter <= '0;
`ifdef UART_RX_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end

        // Mid-start-bit check rejects glitches shorter than half a bit.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt_full) begin
            cnt     <= '0;
            shifter <= {rx_s, shifter[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_full) begin
            cnt   <= '0;
            perr  <= (^shifter) ^ rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt_full) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must not decode as a stream of 0x00 bytes.
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_busy = (state != IDLE);

  // Error pulses never touch the data register, valid or overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rx_data   <= 8'h00;
      bus.rx_valid  <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= stop_tick && !rx_s;
      if (accept) begin
        bus.rx_data  <= shifter;
        bus.rx_valid <= 1'b1;
        if (bus.rx_ack)       bus.overrun <= 1'b0;
        else if (bus.rx_valid) bus.overrun <= 1'b1;
      end else if (bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
        bus.overrun  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.parity_err <= 1'b0;
    else        bus.parity_err <= stop_tick && rx_s && perr;
  end
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-by-bit, accepted bytes are popped on
// rx_valid/overrun rising edges, error pulses and busy time are counted by a negedge monitor.
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 2_500_000;
  localparam int D        = CLK_FREQ / BAUD;
  localparam int H        = D / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_SLOTS = 10;
`else
  localparam int STOP_SLOTS = 9;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic line  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset   (reset),
    .UART_RX (line),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc;
  int valid_rises    = 0;
  int valid_rise_cyc = 0;
  int fe_pulses = 0, fe_long = 0;
  int pe_pulses = 0, pe_long = 0;
  int busy_cycles = 0;
  logic [7:0] sb_q[$];
  logic prev_valid = 1'b0, prev_ovr = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] exp_byte;
    if (bus.rx_valid && !prev_valid) begin
      valid_rises++;
      valid_rise_cyc = cyc;
    end
    if ((bus.rx_valid && !prev_valid) || (bus.overrun && !prev_ovr)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got byte %02h, expected no output", bus.rx_data);
      end else begin
        exp_byte = sb_q.pop_front();
        if (bus.rx_data !== exp_byte) begin
          errors++;
          $display("FAIL sb_data: got %02h, expected %02h", bus.rx_data, exp_byte);
        end
      end
    end
    if (bus.frame_err && !prev_fe) fe_pulses++;
    if (bus.frame_err && prev_fe)  fe_long++;
    if (bus.parity_err && !prev_pe) pe_pulses++;
    if (bus.parity_err && prev_pe)  pe_long++;
    if (bus.rx_busy) busy_cycles++;
    prev_valid = bus.rx_valid;
    prev_ovr   = bus.overrun;
    prev_fe    = bus.frame_err;
    prev_pe    = bus.parity_err;
  end

  function automatic logic [12:0] status();
    return {bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err, bus.overrun};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the stop bit, line left at stop_bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    line = 1'b0;
    start_cyc = cyc;
    wait_cycles(D);
    for (int i = 0; i < 8; i++) begin
      line = data[i];
      wait_cycles(D);
    end
`ifdef UART_RX_PARITY_EN
    line = (^data) ^ par_flip;
    wait_cycles(D);
`else
    if (par_flip) line = 1'b1;
`endif
    line = stop_bit;
    wait_cycles(D);
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    wait_cycles(1);
    bus.rx_ack = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_reset();
    bus.rx_ack = 1'b0;
    line  = 1'b1;
    reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if (bus.rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %02h, expected 00", bus.rx_data);
    end
    checks++;
    if ({bus.rx_valid, bus.rx_busy, bus.overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid/busy/ovr %b, expected 000",
                         {bus.rx_valid, bus.rx_busy, bus.overrun});
    end
    checks++;
    if ({bus.frame_err, bus.parity_err} !== 2'b00) begin
      errors++; $display("FAIL reset_errs: got fe/pe %b, expected 00", {bus.frame_err, bus.parity_err});
    end
  endtask

  task automatic test_basic();
    int v0, f0, p0, exp_cyc;
    v0 = valid_rises; f0 = fe_pulses; p0 = pe_pulses;
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    exp_cyc = start_cyc + 3 + H + STOP_SLOTS * D;
    checks++;
    if (valid_rises != v0 + 1) begin
      errors++; $display("FAIL basic_valid_count: got %0d rises, expected 1", valid_rises - v0);
    end
    checks++;
    if (valid_rise_cyc != exp_cyc && valid_rise_cyc != exp_cyc + 1) begin
      errors++; $display("FAIL basic_latency: valid at cycle %0d, expected %0d", valid_rise_cyc, exp_cyc);
    end
    checks++;
    if (status() !== {8'h55, 5'b10000}) begin
      errors++; $display("FAIL basic_status: got %h, expected %h", status(), {8'h55, 5'b10000});
    end
    checks++;
    if (fe_pulses != f0 || pe_pulses != p0) begin
      errors++; $display("FAIL basic_errs: got fe %0d pe %0d pulses, expected 0 0", fe_pulses - f0, pe_pulses - p0);
    end
    pulse_ack();
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ack: got valid %b, expected 0", bus.rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    sb_q.push_back(8'hF1);
    sb_q.push_back(8'h0F);
    send_frame(8'hF1, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    checks++;
    if (status() !== {8'h0F, 5'b10001}) begin
      errors++; $display("FAIL b2b_overrun: got %h, expected %h", status(), {8'h0F, 5'b10001});
    end
    pulse_ack();
    checks++;
    if (status() !== {8'h0F, 5'b00000}) begin
      errors++; $display("FAIL b2b_ack_clear: got %h, expected %h", status(), {8'h0F, 5'b00000});
    end
  endtask

  task automatic test_glitch();
    int b0, v0, f0, p0;
    b0 = busy_cycles; v0 = valid_rises; f0 = fe_pulses; p0 = pe_pulses;
    line = 1'b0;
    wait_cycles(H / 2);
    line = 1'b1;
    wait_cycles(2 * D);
    checks++;
    if (busy_cycles - b0 != H) begin
      errors++; $display("FAIL glitch_busy: got %0d busy cycles, expected %0d", busy_cycles - b0, H);
    end
    checks++;
    if (valid_rises != v0 || fe_pulses != f0 || pe_pulses != p0) begin
      errors++; $display("FAIL glitch_output: got valid/fe/pe events %0d/%0d/%0d, expected 0/0/0",
                         valid_rises - v0, fe_pulses - f0, pe_pulses - p0);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = fe_pulses;
    send_frame(8'hA3, 1'b0, 1'b0);
    wait_cycles(3 * D);
    checks++;
    if (fe_pulses - f0 != 1 || fe_long != 0) begin
      errors++; $display("FAIL ferr_pulse: got %0d pulses (%0d long cycles), expected 1 (0)", fe_pulses - f0, fe_long);
    end
    checks++;
    if (status() !== {8'h0F, 5'b01000}) begin
      errors++; $display("FAIL ferr_wait_high: got %h, expected %h", status(), {8'h0F, 5'b01000});
    end
    line = 1'b1;
    wait_cycles(4);
    checks++;
    if (bus.rx_busy !== 1'b0) begin
      errors++; $display("FAIL ferr_release: got busy %b, expected 0", bus.rx_busy);
    end
  endtask

  task automatic test_parity();
    sb_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    checks++;
    if (status() !== {8'h07, 5'b10000}) begin
      errors++; $display("FAIL par_good: got %h, expected %h", status(), {8'h07, 5'b10000});
    end
    pulse_ack();
`ifdef UART_RX_PARITY_EN
    begin
      int p0;
      p0 = pe_pulses;
      send_frame(8'h07, 1'b1, 1'b1);
      wait_cycles(2);
      checks++;
      if (pe_pulses - p0 != 1 || pe_long != 0) begin
        errors++; $display("FAIL par_bad_pulse: got %0d pulses (%0d long cycles), expected 1 (0)", pe_pulses - p0, pe_long);
      end
      checks++;
      if (status() !== {8'h07, 5'b00000}) begin
        errors++; $display("FAIL par_bad_status: got %h, expected %h", status(), {8'h07, 5'b00000});
      end
    end
`else
    checks++;
    if (pe_pulses != 0) begin
      errors++; $display("FAIL par_tied: got %0d parity_err pulses, expected 0", pe_pulses);
    end
`endif
  endtask

  task automatic test_ack_collision();
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    // Ack lands on the same edge as the stop sample of the next frame.
    fork
      send_frame(8'h96, 1'b1, 1'b0);
      begin
        repeat (2 + H + STOP_SLOTS * D) @(posedge clk);
        #1 bus.rx_ack = 1'b1;
        @(posedge clk);
        #1 bus.rx_ack = 1'b0;
      end
    join
    checks++;
    if (status() !== {8'h96, 5'b10000}) begin
      errors++; $display("FAIL ack_collision: got %h, expected %h", status(), {8'h96, 5'b10000});
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    line = 1'b0;
    wait_cycles(D);
    for (int i = 0; i < 4; i++) begin
      line = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_cycles(D);
    end
    line = 1'b1;
    wait_cycles(D / 2);
    reset = 1'b0;
    #1;
    checks++;
    if (status() !== 13'h0000) begin
      errors++; $display("FAIL midreset_status: got %h, expected 0000", status());
    end
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(D);
    v0 = valid_rises;
    checks++;
    if (bus.rx_busy !== 1'b0 || valid_rises != v0) begin
      errors++; $display("FAIL midreset_idle: got busy %b, expected 0", bus.rx_busy);
    end
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    checks++;
    if (status() !== {8'h3C, 5'b10000}) begin
      errors++; $display("FAIL midreset_next: got %h, expected %h", status(), {8'h3C, 5'b10000});
    end
    pulse_ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_parity();
    test_ack_collision();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d bytes never delivered, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the MIPS pipelined CPU system. It sits directly upstream of the Peripheral's UART receive data register. It synchronises the asynchronous `UART_RX` pin and deframes 8N1 characters, or 8E1 characters when parity is enabled. It presents each received byte to the Peripheral with a valid/acknowledge handshake, and flags framing, parity and overrun errors so the Peripheral can raise `irqout`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s. Derived `DIVISOR = CLK_FREQ/BAUD` uses integer division, so the default is 5208. Derived `HALF = DIVISOR/2`, default 2604.

- `clk`  in  1  system clock, single clock domain (same as `cpu_clk`).
- `reset`  in  1  asynchronous, active-low reset.
- `UART_RX`  in  1  serial line, asynchronous, idle high.
- `rx_ack`  in  1  one-cycle pulse from the Peripheral when it reads the data register.
- `rx_data`  out  8  last accepted byte.
- `rx_valid`  out  1  high while `rx_data` holds an unread byte.
- `rx_busy`  out  1  high whenever FSM is not IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  sticky: a byte was accepted while `rx_valid` was already 1.

## Operation
- Two-flop synchroniser on `UART_RX`; both flops reset to 1. All logic uses the synchronised value `rx_s`.
- One cycle counter `cnt` (13 bits minimum, sized for `DIVISOR`), a 3-bit bit index, and an 8-bit shifter.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. PARITY exists only with the macro defined.
- IDLE: when `rx_s==0`, go to START and set `cnt=0`.
- START: when `cnt==HALF-1`, sample `rx_s`.
  - If 0, go to DATA with `cnt=0` and bit index 0.
  - If 1 (glitch), return to IDLE and output nothing.
- DATA: when `cnt==DIVISOR-1`, sample the bit and reset `cnt`.
  - Bits are shifted in LSB first.
  - After bit 7, go to PARITY when enabled, otherwise to STOP.
- PARITY: when `cnt==DIVISOR-1`, sample the parity bit and latch `perr = ^shifter ^ bit`. Even parity. Then go to STOP.
- STOP: when `cnt==DIVISOR-1`, sample `rx_s`.
  - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - Else if `perr`: pulse `parity_err`, discard the byte, go to IDLE.
  - Else: accept the byte by loading `rx_data` and setting `rx_valid=1`, then go to IDLE.
- WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. This prevents a break from being decoded as repeated 0x00.
- Accept while `rx_valid==1` and no `rx_ack` that cycle: overwrite `rx_data` and set `overrun=1`.
- `rx_ack`: clears `rx_valid` and `overrun` next cycle. When asserted with `rx_valid==0` it has no effect.
- `rx_ack` and accept in the same cycle: the new byte is loaded, `rx_valid` stays 1, `overrun` is cleared rather than set.
- Errors never modify `rx_data`, `rx_valid` or `overrun`.

## Timing
- Reset values:
  - `rx_data=8'h00`
  - `rx_valid=0`, `rx_busy=0`, `frame_err=0`, `parity_err=0`, `overrun=0`
  - FSM in IDLE, `cnt=0`
- Asserting reset mid-frame aborts immediately. No partial byte is ever delivered.
- Let t0 be the first cycle `rx_s==0`, which is 2 cycles after the pin edge. Samples are taken at:
  - start: t0+HALF
  - data bit i: t0+HALF+(i+1)·DIVISOR
  - parity: t0+HALF+9·DIVISOR
  - stop: t0+HALF+9·DIVISOR without parity, or t0+HALF+10·DIVISOR with it
- Outputs change the cycle after the stop sample:
  - `rx_valid` rises.
  - `frame_err` or `parity_err` pulses high for exactly 1 cycle.
- `rx_busy` rises the cycle after t0. It falls the cycle after the stop sample, or when WAIT_HIGH exits.
- A new start edge is recognised from the first IDLE cycle. Back-to-back frames with zero idle time are received.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1, PARITY state is present, `parity_err` is driven.
- Not defined: frame is 8N1, no PARITY state, `parity_err` is tied 0.
- The port list is identical in both builds.

## Test plan
- Reset release, then frame 0x55 at 9600 baud (bit time 104167 ns), `rx_ack` held 0:
  - `rx_data=0x55` and `rx_valid=1` within 1 cycle after the stop sample.
  - `frame_err`, `parity_err` and `overrun` all stay 0.
- Frames 0xF1, 0x0F back to back with no `rx_ack`:
  - `rx_data=0x0F`, `overrun=1`.
  - One `rx_ack` pulse clears both `rx_valid` and `overrun`.
- Line low for 1000 ns, then high:
  - `rx_busy` pulses for about 2604 cycles.
  - No `rx_valid`, no error pulses.
- Frame 0xA3 with stop bit 0, line held low for 3 more bit times:
  - One 1-cycle `frame_err` pulse, `rx_valid` stays 0.
  - FSM stays in WAIT_HIGH until the line rises.
- Parity build: 0x07 with parity bit 1 is accepted. 0x07 with parity bit 0 gives a 1-cycle `parity_err` and `rx_valid` stays 0.
- Assert reset at data bit 4 of a frame:
  - All outputs return to reset values, FSM to IDLE.
  - The next clean frame 0x3C is received correctly.
